// File: rtl/risc_fsm_controller_if.sv
// ---------------------------------------------------------------------------
// risc_fsm_controller_if
// Bus between the instruction side (master: drives s/instr) and the
// multi-cycle controller (slave: drives the datapath control strobes).
//   s, instr            start strobe and instruction word
//   w, err              ready flag and undecodable-instruction pulse
//   nsel, vsel, write   register-file port select, write-back source, write
//   loada/b/c, loads    pipeline-register and status-register loads
//   asel, bsel          ALU operand selects
//   ALUop, shift        ALU operation and shifter control
//   sximm8, sximm5      sign-extended immediates from the latched instruction
// ---------------------------------------------------------------------------
interface risc_fsm_controller_if #(
   parameter int DW = 16
);
   logic          s;
   logic [15:0]   instr;
   logic          w;
   logic          err;
   logic [2:0]    nsel;
   logic [1:0]    vsel;
   logic          write;
   logic          loada;
   logic          loadb;
   logic          loadc;
   logic          loads;
   logic          asel;
   logic          bsel;
   logic [1:0]    ALUop;
   logic [1:0]    shift;
   logic [DW-1:0] sximm8;
   logic [DW-1:0] sximm5;

   modport master (
      output s, instr,
      input  w, err, nsel, vsel, write, loada, loadb, loadc, loads,
             asel, bsel, ALUop, shift, sximm8, sximm5
   );

   modport slave (
      input  s, instr,
      output w, err, nsel, vsel, write, loada, loadb, loadc, loads,
             asel, bsel, ALUop, shift, sximm8, sximm5
   );
endinterface

// File: rtl/risc_fsm_controller.sv
// ---------------------------------------------------------------------------
// risc_fsm_controller
// Multi-cycle Moore controller for the Simple RISC Machine datapath. Latches
// an instruction on s (only while idle), then steps the datapath through
// operand read, execute and write-back before returning to WAIT.
//   clk    rising-edge clock
//   reset  synchronous, active-high
//   bus    slave side of risc_fsm_controller_if (see interface header)
// ---------------------------------------------------------------------------
module risc_fsm_controller #(
   parameter int DW = 16
) (
   input  logic                   clk,
   input  logic                   reset,
   risc_fsm_controller_if.slave   bus
);

   typedef enum logic [2:0] {
      S_WAIT   = 3'd0,
      S_DECODE = 3'd1,
      S_GET_A  = 3'd2,
      S_GET_B  = 3'd3,
      S_EXEC   = 3'd4,
      S_WR_RD  = 3'd5,
      S_WR_IMM = 3'd6
   } state_t;

   state_t      r_state;
   state_t      w_next;
   logic [15:0] r_ir;

   // instruction fields
   logic [2:0] w_opcode;
   logic [1:0] w_op;
   logic [1:0] w_sh;
   logic       w_mov_imm;
   logic       w_mov_reg;
   logic       w_alu;
   logic       w_mvn;
   logic       w_cmp;

   assign w_opcode  = r_ir[15:13];
   assign w_op      = r_ir[12:11];
   assign w_sh      = r_ir[4:3];
   assign w_mov_imm = (w_opcode == 3'b110) && (w_op == 2'b10);
   assign w_mov_reg = (w_opcode == 3'b110) && (w_op == 2'b00);
   assign w_alu     = (w_opcode == 3'b101);
   assign w_mvn     = w_alu && (w_op == 2'b11);
   assign w_cmp     = w_alu && (w_op == 2'b01);

   assign bus.sximm8 = {{(DW-8){r_ir[7]}}, r_ir[7:0]};
   assign bus.sximm5 = {{(DW-5){r_ir[4]}}, r_ir[4:0]};

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_WAIT;
         r_ir    <= '0;
      end else begin
         r_state <= w_next;
         // capture only while idle so a late s cannot disturb a running op
         if ((r_state == S_WAIT) && bus.s)
            r_ir <= bus.instr;
      end
   end

   always_comb begin
      w_next    = S_WAIT;
      bus.w     = 1'b0;
      bus.err   = 1'b0;
      bus.nsel  = 3'b000;
      bus.vsel  = 2'b00;
      bus.write = 1'b0;
      bus.loada = 1'b0;
      bus.loadb = 1'b0;
      bus.loadc = 1'b0;
      bus.loads = 1'b0;
      bus.asel  = 1'b0;
      bus.bsel  = 1'b0;
      bus.ALUop = 2'b00;
      bus.shift = 2'b00;

      case (r_state)
         S_WAIT: begin
            bus.w  = 1'b1;
            w_next = bus.s ? S_DECODE : S_WAIT;
         end
         S_DECODE: begin
            if (w_mov_imm)
               w_next = S_WR_IMM;
            else if (w_mov_reg || w_mvn)
               w_next = S_GET_B;     // single-operand ops skip the A read
            else if (w_alu)
               w_next = S_GET_A;
            else begin
               bus.err = 1'b1;
               w_next  = S_WAIT;
            end
         end
         S_GET_A: begin
            bus.nsel  = 3'b001;
            bus.loada = 1'b1;
            w_next    = S_GET_B;
         end
         S_GET_B: begin
            bus.nsel  = 3'b100;
            bus.loadb = 1'b1;
            w_next    = S_EXEC;
         end
         S_EXEC: begin
            bus.shift = w_sh;
            if (w_mov_reg) begin
               bus.asel  = 1'b1;    // 0 + shifted Rm
               bus.loadc = 1'b1;
               w_next    = S_WR_RD;
            end else if (w_cmp) begin
               bus.ALUop = 2'b01;   // flags only, no result write-back
               bus.loads = 1'b1;
               w_next    = S_WAIT;
            end else begin
               bus.ALUop = w_op;
               bus.loadc = 1'b1;
               w_next    = S_WR_RD;
            end
         end
         S_WR_RD: begin
            bus.nsel  = 3'b010;
            bus.write = 1'b1;
            w_next    = S_WAIT;
         end
         S_WR_IMM: begin
            bus.nsel  = 3'b001;
            bus.vsel  = 2'b01;
            bus.write = 1'b1;
            w_next    = S_WAIT;
         end
         default: w_next = S_WAIT;
      endcase

      // an aborting reset must not commit state into the datapath this cycle
      if (reset) begin
         bus.err   = 1'b0;
         bus.write = 1'b0;
         bus.loada = 1'b0;
         bus.loadb = 1'b0;
         bus.loadc = 1'b0;
         bus.loads = 1'b0;
      end
   end

endmodule

// File: tb/tb_risc_fsm_controller.sv
// ---------------------------------------------------------------------------
// tb_risc_fsm_controller
// Table of instructions with their per-cycle control outputs; expected
// records are queued when an instruction is launched and popped one per
// cycle as the controller steps. Reset and abort cases are hand sequenced.
// ---------------------------------------------------------------------------
module tb_risc_fsm_controller;

   typedef struct packed {
      logic       w;
      logic       err;
      logic [2:0] nsel;
      logic [1:0] vsel;
      logic       write;
      logic       loada;
      logic       loadb;
      logic       loadc;
      logic       loads;
      logic       asel;
      logic       bsel;
      logic [1:0] alu;
      logic [1:0] shift;
   } out_t;

   typedef struct {
      string       name;
      logic [15:0] instr;
      int          n;
      out_t        seq [6];
      logic [15:0] x8;
      logic [15:0] x5;
   } vec_t;

   logic clk;
   logic reset;
   int   errors;
   int   checks;
   out_t sb [$];
   vec_t vt [8];

   risc_fsm_controller_if #(.DW(16)) bus ();

   risc_fsm_controller #(.DW(16)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic out_t mk(input logic w, input logic err, input logic [2:0] nsel,
                               input logic [1:0] vsel, input logic wr, input logic la,
                               input logic lb, input logic lc, input logic ls,
                               input logic asel, input logic [1:0] alu, input logic [1:0] sh);
      out_t o;
      o.w = w; o.err = err; o.nsel = nsel; o.vsel = vsel; o.write = wr;
      o.loada = la; o.loadb = lb; o.loadc = lc; o.loads = ls;
      o.asel = asel; o.bsel = 1'b0; o.alu = alu; o.shift = sh;
      return o;
   endfunction

   function automatic out_t sample();
      out_t o;
      o.w = bus.w; o.err = bus.err; o.nsel = bus.nsel; o.vsel = bus.vsel;
      o.write = bus.write; o.loada = bus.loada; o.loadb = bus.loadb;
      o.loadc = bus.loadc; o.loads = bus.loads; o.asel = bus.asel;
      o.bsel = bus.bsel; o.alu = bus.ALUop; o.shift = bus.shift;
      return o;
   endfunction

   task automatic chk_out(input string nm, input out_t exp);
      out_t act;
      act = sample();
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %05h expected %05h", nm, act, exp);
      end
   endtask

   task automatic chk16(input string nm, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %04h expected %04h", nm, act, exp);
      end
   endtask

   task automatic add(input int i, input string nm, input logic [15:0] ins, input int n,
                      input out_t a, input out_t b, input out_t c, input out_t d,
                      input out_t e, input out_t f, input logic [15:0] x8,
                      input logic [15:0] x5);
      vt[i].name = nm; vt[i].instr = ins; vt[i].n = n;
      vt[i].seq[0] = a; vt[i].seq[1] = b; vt[i].seq[2] = c;
      vt[i].seq[3] = d; vt[i].seq[4] = e; vt[i].seq[5] = f;
      vt[i].x8 = x8; vt[i].x5 = x5;
   endtask

   // Launch one instruction, then pop one expected record per cycle.
   // Inside the busy window s is re-pulsed and instr scrambled; neither may
   // disturb the sequence or the latched immediates.
   task automatic run(input int i);
      out_t exp;
      @(negedge clk);
      bus.s = 1'b1;
      bus.instr = vt[i].instr;
      for (int k = 0; k < vt[i].n; k++) sb.push_back(vt[i].seq[k]);
      for (int k = 0; k < vt[i].n; k++) begin
         @(negedge clk);
         if (sb.size() == 0) begin
            checks++; errors++;
            $display("FAIL %s: scoreboard empty at cycle %0d", vt[i].name, k);
         end else begin
            exp = sb.pop_front();
            chk_out($sformatf("%s c%0d", vt[i].name, k), exp);
         end
         if (k == 0 || k == vt[i].n - 1) begin
            chk16({vt[i].name, " sximm8"}, bus.sximm8, vt[i].x8);
            chk16({vt[i].name, " sximm5"}, bus.sximm5, vt[i].x5);
         end
         bus.instr = 16'hFFFF;
         bus.s = (k == 0) && (vt[i].n > 2);
      end
      bus.s = 1'b0;
   endtask

   out_t IDLE, DEC, ERR;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      errors = 0;
      checks = 0;
      IDLE = mk(1,0,3'b000,2'b00,0,0,0,0,0,0,2'b00,2'b00);
      DEC  = mk(0,0,3'b000,2'b00,0,0,0,0,0,0,2'b00,2'b00);
      ERR  = mk(0,1,3'b000,2'b00,0,0,0,0,0,0,2'b00,2'b00);

      //        name     instr    n  c0   c1 ...                                        x8       x5
      add(0, "movimm", 16'hD007, 3, DEC,
          mk(0,0,3'b001,2'b01,1,0,0,0,0,0,2'b00,2'b00), IDLE, IDLE, IDLE, IDLE,
          16'h0007, 16'h0007);
      add(1, "add",    16'hA148, 6, DEC,
          mk(0,0,3'b001,2'b00,0,1,0,0,0,0,2'b00,2'b00),
          mk(0,0,3'b100,2'b00,0,0,1,0,0,0,2'b00,2'b00),
          mk(0,0,3'b000,2'b00,0,0,0,1,0,0,2'b00,2'b01),
          mk(0,0,3'b010,2'b00,1,0,0,0,0,0,2'b00,2'b00), IDLE,
          16'h0048, 16'h0008);
      add(2, "cmp",    16'hA900, 5, DEC,
          mk(0,0,3'b001,2'b00,0,1,0,0,0,0,2'b00,2'b00),
          mk(0,0,3'b100,2'b00,0,0,1,0,0,0,2'b00,2'b00),
          mk(0,0,3'b000,2'b00,0,0,0,0,1,0,2'b01,2'b00), IDLE, IDLE,
          16'h0000, 16'h0000);
      add(3, "mvn",    16'hB864, 5, DEC,
          mk(0,0,3'b100,2'b00,0,0,1,0,0,0,2'b00,2'b00),
          mk(0,0,3'b000,2'b00,0,0,0,1,0,0,2'b11,2'b00),
          mk(0,0,3'b010,2'b00,1,0,0,0,0,0,2'b00,2'b00), IDLE, IDLE,
          16'h0064, 16'h0004);
      add(4, "movreg", 16'hC0A6, 5, DEC,
          mk(0,0,3'b100,2'b00,0,0,1,0,0,0,2'b00,2'b00),
          mk(0,0,3'b000,2'b00,0,0,0,1,0,1,2'b00,2'b00),
          mk(0,0,3'b010,2'b00,1,0,0,0,0,0,2'b00,2'b00), IDLE, IDLE,
          16'hFFA6, 16'h0006);
      add(5, "illegal0", 16'h0000, 2, ERR, IDLE, IDLE, IDLE, IDLE, IDLE,
          16'h0000, 16'h0000);
      add(6, "and",    16'hB2F0, 6, DEC,
          mk(0,0,3'b001,2'b00,0,1,0,0,0,0,2'b00,2'b00),
          mk(0,0,3'b100,2'b00,0,0,1,0,0,0,2'b00,2'b00),
          mk(0,0,3'b000,2'b00,0,0,0,1,0,0,2'b10,2'b10),
          mk(0,0,3'b010,2'b00,1,0,0,0,0,0,2'b00,2'b00), IDLE,
          16'hFFF0, 16'hFFF0);
      add(7, "illegalD8", 16'hD8FF, 2, ERR, IDLE, IDLE, IDLE, IDLE, IDLE,
          16'hFFFF, 16'hFFFF);

      // reset dominates a held start strobe
      reset = 1'b1;
      bus.s = 1'b1;
      bus.instr = 16'hD007;
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         chk_out($sformatf("reset c%0d", k), IDLE);
         chk16("reset sximm8", bus.sximm8, 16'h0000);
         chk16("reset sximm5", bus.sximm5, 16'h0000);
      end
      bus.s = 1'b0;
      reset = 1'b0;
      @(negedge clk);
      chk_out("post-reset idle", IDLE);

      for (int i = 0; i < 8; i++) run(i);

      // abort an ADD during GET_B: nothing may be written or latched into C
      @(negedge clk);
      bus.s = 1'b1;
      bus.instr = 16'hA148;
      @(negedge clk);
      bus.s = 1'b0;
      chk_out("abort decode", DEC);
      @(negedge clk);
      chk_out("abort get_a", mk(0,0,3'b001,2'b00,0,1,0,0,0,0,2'b00,2'b00));
      @(negedge clk);
      chk_out("abort get_b", mk(0,0,3'b100,2'b00,0,0,1,0,0,0,2'b00,2'b00));
      reset = 1'b1;
      #1;
      checks++;
      if (bus.write !== 1'b0 || bus.loadc !== 1'b0 || bus.loads !== 1'b0) begin
         errors++;
         $display("FAIL abort commit: got write=%b loadc=%b loads=%b expected 0 0 0",
                  bus.write, bus.loadc, bus.loads);
      end
      @(negedge clk);
      chk_out("abort wait", IDLE);
      reset = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk_out($sformatf("abort idle c%0d", k), IDLE);
      end

      if (sb.size() != 0) begin
         checks++; errors++;
         $display("FAIL scoreboard drain: got %0d left expected 0", sb.size());
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/risc_fsm_controller.md
Name: risc_fsm_controller

Overview:
Multi-cycle controller for the Simple RISC Machine datapath: register file, A/B/C pipeline registers, shifter, the 16-bit ALU, and the status register (Z/N/V).
- Latches an instruction word on a start strobe and decodes it.
- Steps the datapath through read-operand, execute and write-back cycles using load/select/write strobes.
- Returns to an idle Wait state and raises `w` when the instruction is done.
- Sits between the instruction register and the datapath.

Parameters:
- DW, 16: datapath width; width of `sximm8` and `sximm5` outputs (sign extension target).

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- s  in  1  start strobe; sampled only in WAIT
- instr  in  16  instruction word; captured into internal `ir` when s=1 in WAIT
- w  out  1  1 = idle/ready (WAIT state)
- err  out  1  one-cycle pulse on an undecodable instruction
- nsel  out  3  register-file port select, one-hot: 001=Rn, 010=Rd, 100=Rm, 000=none
- vsel  out  2  write-back source: 00=C, 01=sximm8, 10/11 reserved (never driven)
- write  out  1  register-file write enable
- loada  out  1  load A register
- loadb  out  1  load B register
- loadc  out  1  load C register
- loads  out  1  load status register from ALU Z/N/V
- asel  out  1  1 = force ALU A input to zero
- bsel  out  1  1 = ALU B input from sximm5 (always 0 in this instruction set)
- ALUop  out  2  ALU operation (00 add, 01 sub, 10 and, 11 not-B)
- shift  out  2  shifter control
- sximm8  out  DW  ir[7:0] sign-extended
- sximm5  out  DW  ir[4:0] sign-extended

Behaviour:
- Instruction fields in `ir`:
  - opcode = [15:13], op = [12:11], Rn = [10:8], Rd = [7:5], sh = [4:3], Rm = [2:0], imm8 = [7:0].
- Decoded instruction classes:
  - MOV_IMM: opcode 110, op 10
  - MOV_REG: opcode 110, op 00
  - ALU: opcode 101; op 00 = ADD, 01 = CMP, 10 = AND, 11 = MVN
  - Anything else is illegal.
- Output style: Moore. Strobes are decoded from state and `ir` only. All strobes, nsel, ALUop and shift are 0 in any state not listed below as driving them. sximm8/sximm5 are continuous functions of `ir`.
- Reset:
  - state = WAIT, ir = 0.
  - Outputs after reset: w = 1, err = 0, all strobes 0, nsel = 000, vsel = 00, ALUop = 00, shift = 00, sximm8 = 0, sximm5 = 0.
  - Reset takes priority over s.
  - Reset asserted mid-instruction returns to WAIT on the next edge, with no write or loads issued in that cycle.
- States and transitions:
  - WAIT: w = 1. If s = 1: ir <= instr, go to DECODE. Otherwise stay.
  - DECODE:
    - MOV_IMM -> WR_IMM
    - MOV_REG -> GET_B
    - MVN -> GET_B
    - ADD/CMP/AND -> GET_A
    - Illegal -> WAIT with err = 1 for that DECODE cycle (err asserted combinationally in DECODE)
  - GET_A: nsel = Rn, loada = 1 -> GET_B.
  - GET_B: nsel = Rm, loadb = 1 -> EXEC.
  - EXEC: shift = sh, bsel = 0.
    - MOV_REG: asel = 1, ALUop = 00, loadc = 1 -> WR_RD
    - ADD/AND/MVN: asel = 0 (MVN: don't care, driven 0), ALUop = op, loadc = 1 -> WR_RD
    - CMP: ALUop = 01, loads = 1, loadc = 0 -> WAIT
  - WR_RD: nsel = Rd, vsel = 00, write = 1 -> WAIT.
  - WR_IMM: nsel = Rn, vsel = 01, write = 1 -> WAIT.
- Latency: w is low for the following number of cycles after the s-sampling edge:
  - MOV_IMM: 2
  - MOV_REG, MVN, CMP: 4
  - ADD, AND: 5
  - Illegal: 1
- `s` while w = 0 is ignored. `instr` may change freely after capture.
- Exactly one of write, loads, or none occurs per instruction. No state issues both write and loadc.
- Unused state encodings return to WAIT on the next edge.

Test Plan:
- reset=1 for 2 cycles, s=1 held -> w=1, all strobes 0, nsel=000, sximm8=0; no transition while reset is high.
- instr=0xD007 (MOV R0,#7), s pulse -> DECODE, then WR_IMM: nsel=001, vsel=01, write=1, sximm8=0x0007; w returns to 1 two cycles after capture.
- instr=0xA148 (ADD R2,R1,R0 LSL#1) -> GET_A (nsel=001, loada), GET_B (nsel=100, loadb), EXEC (ALUop=00, shift=01, loadc), WR_RD (nsel=010, write); w low for 5 cycles. Change instr to 0xFFFF during execution -> sequence unaffected.
- instr=0xA900 (CMP R1,R0) -> EXEC drives ALUop=01, loads=1, loadc=0, write never asserted; MVN 0xB864 skips GET_A, EXEC ALUop=11; MOV 0xC0A6 EXEC asel=1, ALUop=00, WR_RD nsel=010.
- instr=0x0000, s pulse -> err=1 for exactly one cycle in DECODE, no strobe asserted, w=1 on the next cycle.
- ADD started, reset asserted during GET_B -> next edge in WAIT, write and loadc never asserted; a second s during any busy cycle -> ignored, ir unchanged.
